tape_fifo_uart_tx: RTL and testbench

//  Drains FIFO_out (bytes from the tape-out decoder: wav, turbo or tap stream) and sends each byte
//  on serial_tx as 8N1 UART to the host PC. Sits directly downstream of FIFO_out.

---
 rtl/tape_fifo_uart_tx_pkg.sv | 23 ++
 rtl/tape_fifo_uart_tx_uart_bit_timer.sv | 36 +++
 rtl/tape_fifo_uart_tx.sv | 158 +++++++++++++++
 tb/tb_tape_fifo_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO_out -> host UART transmitter: FSM encoding,
// default clock/baud figures and the idle line level.
package tape_fifo_uart_tx_pkg;

  localparam int unsigned DEFAULT_CLOCK_HZ = 56_840_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;
  localparam int unsigned MIN_CLKS_PER_BIT = 4;
  localparam logic        UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  function automatic int unsigned clamp_cpb(input int unsigned cpb);
    return (cpb < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : cpb;
  endfunction

endpackage

// File: rtl/tape_fifo_uart_tx_uart_bit_timer.sv
// Loadable bit-period down-counter; o_bit_done is high while the count sits at zero.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  output logic o_bit_done
);

  localparam int unsigned    CW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Saturates at zero so an idle timer never wraps back into a bit period.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_bit_done = (count_q == '0);

endmodule

// File: rtl/tape_fifo_uart_tx.sv
// Drains FIFO_out as 8N1 UART frames to the host and flags writes into a full FIFO.
// Optional host flow control gate: define TAPE_TX_CTS_EN to add i_cts_n.
module tape_fifo_uart_tx
  import tape_fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLOCK_HZ     = DEFAULT_CLOCK_HZ,
  parameter int unsigned BAUD         = DEFAULT_BAUD,
  parameter int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_read_req,
  input  logic        i_fifo_full,
  input  logic        i_fifo_write_req,
  output logic        o_serial_tx,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [15:0] o_bytes_sent
`ifdef TAPE_TX_CTS_EN
  ,
  input  logic        i_cts_n
`endif
);

  localparam int unsigned CPB = clamp_cpb(CLKS_PER_BIT);

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        overflow_q, overflow_d;
  logic [15:0] bytes_sent_q, bytes_sent_d;
  logic        timer_load;
  logic        bit_done;
  logic        cts_open;

`ifdef TAPE_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Reset to "not clear" so nothing is fetched until the host is seen ready.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= i_cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_open = ~cts_sync_q;
`else
  assign cts_open = 1'b1;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT (CPB)
  ) u_bit_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (timer_load),
    .o_bit_done (bit_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The CTS gate is only consulted in IDLE, so a started frame always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!i_fifo_empty && cts_open) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_START;
      ST_START: if (bit_done) state_d = ST_DATA;
      ST_DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (bit_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_read_req = (state_q == ST_FETCH);
    o_busy          = (state_q != ST_IDLE);
  end

  // The line level is registered one edge ahead of each bit so it changes
  // on the same edge the timer is reloaded.
  always_comb begin
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = tx_q;
    bytes_sent_d = bytes_sent_q;
    timer_load   = 1'b0;
    overflow_d   = overflow_q | (i_fifo_full & i_fifo_write_req);
    unique case (state_q)
      ST_IDLE, ST_FETCH: tx_d = UART_IDLE_LEVEL;
      ST_LATCH: begin
        shift_d    = i_fifo_data;
        tx_d       = ~UART_IDLE_LEVEL;
        timer_load = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          tx_d       = shift_q[0];
          bit_idx_d  = '0;
          timer_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_load = 1'b1;
          if (bit_idx_q == 3'd7) begin
            tx_d = UART_IDLE_LEVEL;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          bytes_sent_d = bytes_sent_q + 16'd1;
        end
      end
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q      <= '0;
      bit_idx_q    <= '0;
      tx_q         <= UART_IDLE_LEVEL;
      overflow_q   <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      overflow_q   <= overflow_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  assign o_serial_tx  = tx_q;
  assign o_overflow   = overflow_q;
  assign o_bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_tape_fifo_uart_tx.sv
// Self-checking bench for tape_fifo_uart_tx at CLKS_PER_BIT=4 (TAPE_TX_CTS_EN optional).
module tb_tape_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty;
  logic [7:0]  fdata;
  logic        rdreq;
  logic        full;
  logic        wr;
  logic        tx;
  logic        busy;
  logic        ovf;
  logic [15:0] bsent;
`ifdef TAPE_TX_CTS_EN
  logic        cts_n;
`endif

  always #5 clk = ~clk;

  tape_fifo_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_fifo_empty     (empty),
    .i_fifo_data      (fdata),
    .o_fifo_read_req  (rdreq),
    .i_fifo_full      (full),
    .i_fifo_write_req (wr),
    .o_serial_tx      (tx),
    .o_busy           (busy),
    .o_overflow       (ovf),
    .o_bytes_sent     (bsent)
`ifdef TAPE_TX_CTS_EN
    ,
    .i_cts_n          (cts_n)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
    end
  endtask

  // ---------------- FIFO_out model (show-ahead off: data the cycle after rdreq)
  byte unsigned src[$];      // every byte ever pushed, in order (written by stimulus only)
  int  rd_idx    = 0;        // bytes popped by the DUT
  int  rd_pulses = 0;
  int  underflow = 0;
  int  cyc       = 0;
  logic rd_prev  = 1'b0;
  logic reset_seen = 1'b0;

  initial begin
    empty = 1'b1;
    fdata = 8'h00;
  end

  always @(posedge clk) begin
    cyc++;
    reset_seen <= rst;
    if (rdreq) begin
      rd_pulses++;
      chk("rdreq_single_cycle", {31'd0, rd_prev}, 32'd0);
      if (rd_idx >= src.size()) begin
        underflow++;
      end else begin
        fdata <= src[rd_idx];
        rd_idx++;
      end
    end
    rd_prev = rdreq;
    empty <= (rd_idx >= src.size());
  end

  // ---------------- line receiver: checks each frame against the byte the DUT popped
  logic        rx_active = 1'b0;
  int          rx_pos    = 0;
  int          rx_idx    = 0;
  logic [7:0]  rx_byte   = 8'h00;
  int          start_cyc[$];

  function automatic logic frame_level(input logic [7:0] b, input int pos);
    int bit_no;
    bit_no = pos / CPB;
    if (bit_no == 0) return 1'b0;
    if (bit_no == 9) return 1'b1;
    return b[bit_no - 1];
  endfunction

  always @(negedge clk) begin
    if (reset_seen) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1'b1;
        rx_pos    = 0;
        start_cyc.push_back(cyc);
        chk("frame_had_pop", {31'd0, rx_idx < rd_idx}, 32'd1);
        rx_byte = (rx_idx < src.size()) ? src[rx_idx] : 8'h00;
        rx_idx++;
      end
      if (rx_active) begin
        chk("line_level", {31'd0, tx}, {31'd0, frame_level(rx_byte, rx_pos)});
        rx_pos++;
        if (rx_pos == FRAME) rx_active = 1'b0;
      end
    end
  end

  // ---------------- helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int waited;
    waited = 0;
    while (!(rd_idx == src.size() && !busy && !rx_active && empty) && waited < budget) begin
      tick(1);
      waited++;
    end
    if (waited >= budget) chk("wait_idle_timeout", 32'd0, 32'd1);
    tick(2);
  endtask

  task automatic wait_tx_low(input int budget, output int lat);
    lat = 0;
    while (tx !== 1'b0 && lat < budget) begin
      tick(1);
      lat++;
    end
    if (lat >= budget) chk("start_bit_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [9:0]  frame;      // line level per bit time, index 0 = start bit
    logic [15:0] cnt_after;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] model_cnt;
  logic        ovf_model;
  int          rd0, st0, lat;

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b11_0100_1010, cnt_after: 16'd1};
    vecs[1] = '{data: 8'h01, frame: 10'b10_0000_0010, cnt_after: 16'd2};
    vecs[2] = '{data: 8'h80, frame: 10'b11_0000_0000, cnt_after: 16'd3};
    vecs[3] = '{data: 8'hC3, frame: 10'b11_1000_0110, cnt_after: 16'd4};

    rst  = 1'b1;
    full = 1'b0;
    wr   = 1'b0;
`ifdef TAPE_TX_CTS_EN
    cts_n = 1'b0;
`endif
    tick(3);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_rdreq", {31'd0, rdreq}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_overflow", {31'd0, ovf}, 32'd0);
    chk("reset_count", {16'd0, bsent}, 32'd0);
    rst = 1'b0;
    tick(4);

    // single bytes: latency, rdreq, exact line waveform and count
    foreach (vecs[i]) begin
      rd0 = rd_pulses;
      src.push_back(vecs[i].data);
      lat = 0;
      while (empty !== 1'b0 && lat < 10) begin tick(1); lat++; end
      tick(1);
      chk("rdreq_after_empty_drop", {31'd0, rdreq}, 32'd1);
      lat = 1;
      while (tx !== 1'b0 && lat < 20) begin tick(1); lat++; end
      chk("start_latency", lat, 32'd3);
      for (int k = 0; k < FRAME; k++) begin
        chk("vec_frame", {31'd0, tx}, {31'd0, vecs[i].frame[k / CPB]});
        tick(1);
      end
      wait_idle(200);
      chk("vec_count", {16'd0, bsent}, {16'd0, vecs[i].cnt_after});
      chk("vec_rdreq_pulses", rd_pulses - rd0, 32'd1);
    end
    model_cnt = 16'd4;

    // back-to-back frames
    rd0 = rd_pulses;
    st0 = start_cyc.size();
    src.push_back(8'h00);
    src.push_back(8'hFF);
    src.push_back(8'h55);
    wait_idle(500);
    model_cnt += 16'd3;
    chk("b2b_frames", start_cyc.size() - st0, 32'd3);
    if (start_cyc.size() - st0 == 3) begin
      chk("b2b_period_1", start_cyc[st0 + 1] - start_cyc[st0], 32'(FRAME + 3));
      chk("b2b_period_2", start_cyc[st0 + 2] - start_cyc[st0 + 1], 32'(FRAME + 3));
    end
    chk("b2b_rdreq_pulses", rd_pulses - rd0, 32'd3);
    chk("b2b_count", {16'd0, bsent}, {16'd0, model_cnt});

    // overflow flag: full alone does nothing, full+write sets and sticks
    src.push_back(8'h96);
    tick(8);
    full = 1'b1;
    tick(2);
    chk("full_without_write", {31'd0, ovf}, 32'd0);
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    chk("overflow_set", {31'd0, ovf}, 32'd1);
    tick(5);
    full = 1'b0;
    wait_idle(200);
    model_cnt += 16'd1;
    chk("overflow_sticky", {31'd0, ovf}, 32'd1);
    chk("overflow_no_flow_effect", {16'd0, bsent}, {16'd0, model_cnt});

    // count wrap
    force dut.bytes_sent_q = 16'hFFFF;
    tick(1);
    release dut.bytes_sent_q;
    tick(1);
    chk("count_preload", {16'd0, bsent}, 32'h0000_FFFF);
    src.push_back(8'h5A);
    wait_idle(200);
    chk("count_wrap", {16'd0, bsent}, 32'd0);

    // reset during the third data bit, together with an overflow event
    src.push_back(8'h3C);
    wait_tx_low(20, lat);
    tick(2 * CPB + CPB);
    rst  = 1'b1;
    full = 1'b1;
    wr   = 1'b1;
    tick(1);
    chk("midbyte_reset_tx", {31'd0, tx}, 32'd1);
    chk("midbyte_reset_busy", {31'd0, busy}, 32'd0);
    chk("midbyte_reset_count", {16'd0, bsent}, 32'd0);
    chk("reset_beats_overflow", {31'd0, ovf}, 32'd0);
    rst  = 1'b0;
    full = 1'b0;
    wr   = 1'b0;
    rd0  = rd_pulses;
    tick(30);
    chk("no_rdreq_after_reset", rd_pulses - rd0, 32'd0);
    chk("idle_after_reset", {30'd0, busy, tx}, 32'd1);

    // randomized traffic with random overflow events
    model_cnt = 16'd0;
    ovf_model = 1'b0;
    rd0 = rd_pulses;
    st0 = start_cyc.size();
    for (int n = 0; n < 24; n++) begin
      src.push_back(8'($urandom_range(0, 255)));
      for (int g = 0, gap = $urandom_range(0, 55); g < gap; g++) begin
        full = ($urandom_range(0, 3) == 0);
        wr   = ($urandom_range(0, 7) == 0);
        ovf_model = ovf_model | (full & wr);
        tick(1);
        chk("rand_overflow", {31'd0, ovf}, {31'd0, ovf_model});
      end
    end
    full = 1'b0;
    wr   = 1'b0;
    wait_idle(3000);
    chk("rand_rdreq_pulses", rd_pulses - rd0, 32'd24);
    chk("rand_frames", start_cyc.size() - st0, 32'd24);
    chk("rand_count", {16'd0, bsent}, 32'd24);
    chk("underflow_reads", underflow, 32'd0);

`ifdef TAPE_TX_CTS_EN
    // host flow control
    cts_n = 1'b1;
    tick(4);
    rd0 = rd_pulses;
    src.push_back(8'hE1);
    src.push_back(8'h1E);
    tick(20);
    chk("cts_blocks_fetch", rd_pulses - rd0, 32'd0);
    cts_n = 1'b0;
    wait_tx_low(20, lat);
    chk("cts_start_within_5", {31'd0, lat <= 5}, 32'd1);
    tick(12);
    cts_n = 1'b1;
    tick(FRAME + 20);
    chk("cts_frame_completes", {16'd0, bsent}, 32'd25);
    chk("cts_next_waits", rd_pulses - rd0, 32'd1);
    cts_n = 1'b0;
    wait_idle(300);
    chk("cts_drain", {16'd0, bsent}, 32'd26);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
